// File: rtl/param_traffic_controller_if.sv
// param_traffic_controller_if
//   Signal bundle between the intersection controller and its surroundings.
//   master: drives the pedestrian button and vehicle sensor, observes lights.
//   slave : the controller; samples requests, drives lights and walk countdown.
//   walk_button  pedestrian request (level)
//   sensor       side-street vehicle presence (level)
//   main_light   00 RED, 01 YELLOW, 10 GREEN
//   side_light   same encoding
//   walk_light   1 = walk
//   walk_count   walk cycles remaining including the current one, 0 outside WALK
interface param_traffic_controller_if #(
  parameter int CNT_W = 8
);
  logic             walk_button;
  logic             sensor;
  logic [1:0]       main_light;
  logic [1:0]       side_light;
  logic             walk_light;
  logic [CNT_W-1:0] walk_count;

  modport master (
    output walk_button, sensor,
    input  main_light, side_light, walk_light, walk_count
  );

  modport slave (
    input  walk_button, sensor,
    output main_light, side_light, walk_light, walk_count
  );
endinterface

// File: rtl/param_traffic_controller.sv
// param_traffic_controller
//   Two-road intersection controller with pedestrian phase, side-green
//   extension on sensor, all-red clearance after every yellow and a walk
//   countdown. Moore outputs decoded from registered state and phase timer.
// Ports:
//   clk  phase clock, one cycle per tick
//   rst  synchronous active-high reset
//   tc   param_traffic_controller_if.slave (requests in, lights/countdown out)
// Build option:
//   TC_WALK_FLASH_EN  when defined, walk_light toggles during the last FLASH_T
//                     WALK cycles (starting dark); otherwise steady for all of WALK.
//
// state | meaning
// ------+------------------------------------------------
// MG    | main green, side red; holds until a request after minimum green
// MY    | main yellow, side red
// CLR   | all red clearance after either yellow
// WALK  | all red, pedestrians walk
// SG    | side green, main red; extended while sensor stays high
// SY    | side yellow, main red
module param_traffic_controller #(
  parameter int MAIN_GREEN_MIN = 6,
  parameter int YELLOW_T       = 2,
  parameter int CLEAR_T        = 1,
  parameter int SIDE_GREEN_MIN = 4,
  parameter int SIDE_GREEN_MAX = 8,
  parameter int WALK_T         = 5,
  parameter int FLASH_T        = 2,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  param_traffic_controller_if.slave tc
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_CLR  = 3'd2,
    S_WALK = 3'd3,
    S_SG   = 3'd4,
    S_SY   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MG_LAST     = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(CLEAR_T - 1);
  localparam logic [CNT_W-1:0] W_LAST      = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] W_LEN       = CNT_W'(WALK_T);
  localparam logic [CNT_W-1:0] SG_MIN_LAST = CNT_W'(SIDE_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SG_MAX_LAST = CNT_W'(SIDE_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] FLASH_LEN   = CNT_W'(FLASH_T);
  localparam bit               FLASH_ODD   = (FLASH_T % 2) == 1;
`ifdef TC_WALK_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             walk_req_q, walk_req_d;
  logic             side_req_q, side_req_d;
  logic             clr_from_my_q, clr_from_my_d;
  logic             enter;
  logic [CNT_W-1:0] walk_cnt;
  logic             flash_dark;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_MG;
      timer_q       <= '0;
      walk_req_q    <= 1'b0;
      side_req_q    <= 1'b0;
      clr_from_my_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      walk_req_q    <= walk_req_d;
      side_req_q    <= side_req_d;
      clr_from_my_q <= clr_from_my_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MG: begin
        if (timer_q >= MG_LAST &&
            (walk_req_q || side_req_q || tc.walk_button || tc.sensor))
          state_d = S_MY;
      end
      S_MY: if (timer_q == Y_LAST) state_d = S_CLR;
      S_CLR: begin
        if (timer_q == C_LAST) begin
          if (walk_req_q)                        state_d = S_WALK;
          else if (clr_from_my_q && side_req_q)  state_d = S_SG;
          else                                   state_d = S_MG;
        end
      end
      // vehicles are already red, so WALK hands straight over to SG
      S_WALK: if (timer_q == W_LAST) state_d = side_req_q ? S_SG : S_MG;
      S_SG: begin
        if (timer_q == SG_MAX_LAST ||
            (timer_q >= SG_MIN_LAST && (!tc.sensor || walk_req_q)))
          state_d = S_SY;
      end
      S_SY: if (timer_q == Y_LAST) state_d = S_CLR;
      default: state_d = S_MG;
    endcase

    enter = (state_d != state_q);

    // MG may hold forever, so its timer parks at the minimum-green mark
    if (enter)
      timer_d = '0;
    else if (state_q == S_MG && timer_q >= MG_LAST)
      timer_d = timer_q;
    else
      timer_d = timer_q + CNT_W'(1);

    // set terms include the current cycle so a request on a transition edge is kept
    walk_req_d = (walk_req_q || (tc.walk_button && state_q != S_WALK)) &&
                 !(enter && state_d == S_WALK);
    side_req_d = (side_req_q ||
                  (tc.sensor && (state_q == S_MG || state_q == S_MY || state_q == S_CLR))) &&
                 !(enter && state_d == S_SG);

    clr_from_my_d = clr_from_my_q;
    if (enter && state_d == S_CLR)
      clr_from_my_d = (state_q == S_MY);
  end

  always_comb begin
    walk_cnt = (state_q == S_WALK) ? (W_LEN - timer_q) : '0;
    // flash phase starts dark on its first cycle, so dark when (FLASH_T - count) is even
    flash_dark = FLASH_EN && (state_q == S_WALK) && (walk_cnt <= FLASH_LEN) &&
                 !(walk_cnt[0] ^ FLASH_ODD);

    tc.main_light = 2'b00;
    tc.side_light = 2'b00;
    case (state_q)
      S_MG: tc.main_light = 2'b10;
      S_MY: tc.main_light = 2'b01;
      S_SG: tc.side_light = 2'b10;
      S_SY: tc.side_light = 2'b01;
      default: ;
    endcase
    tc.walk_light = (state_q == S_WALK) && !flash_dark;
    tc.walk_count = walk_cnt;
  end

endmodule
